// File: rtl/qick_pkg.sv
// qick_pkg: shared definitions for the qick processor core.
//   - Register-map region bases and fixed register addresses (7-bit space).
//   - WAVE_REG_T: the six 32-bit wave fields, field 0 in bits [31:0].
package qick_pkg;

   localparam logic [6:0] SREG_BASE    = 7'h00;
   localparam logic [6:0] WREG_BASE    = 7'h20;
   localparam logic [6:0] DREG_BASE    = 7'h40;

   localparam logic [6:0] REG_TIME     = 7'h01;
   localparam logic [6:0] REG_STATUS   = 7'h02;
   localparam logic [6:0] REG_JMP_ADDR = 7'h4F;

   localparam int WAVE_FIELDS = 6;

   typedef logic [WAVE_FIELDS-1:0][31:0] WAVE_REG_T;

endpackage

// File: rtl/qcore_wreg.sv
// qcore_wreg: the wave register (w0..w5).
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   halt_i          : freezes the register (pending load/write dropped)
//   wmem_ld_i       : load all six fields from wmem_dt_i
//   wmem_dt_i       : wave word from wave memory
//   wr_we_i/addr/dt : write-back port; only addresses w0..w5 affect this block
//   wreg_o          : current wave register contents
module qcore_wreg
   import qick_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        halt_i,
   input  logic        wmem_ld_i,
   input  WAVE_REG_T   wmem_dt_i,
   input  logic        wr_we_i,
   input  logic [6:0]  wr_addr_i,
   input  logic [31:0] wr_dt_i,
   output WAVE_REG_T   wreg_o
);

   WAVE_REG_T wreg_q;
   WAVE_REG_T wreg_d;

   // A write-back to one field overrides the whole-word load for that field
   // only; the remaining fields still take the load.
   always_comb begin
      wreg_d = wreg_q;
      if (!halt_i) begin
         for (int i = 0; i < WAVE_FIELDS; i++) begin
            if (wr_we_i && (wr_addr_i == 7'(WREG_BASE + 7'(i))))
               wreg_d[i] = wr_dt_i;
            else if (wmem_ld_i)
               wreg_d[i] = wmem_dt_i[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) wreg_q <= '0;
      else         wreg_q <= wreg_d;
   end

   assign wreg_o = wreg_q;

endmodule

// File: rtl/qcore_reg_bank.sv
// qcore_reg_bank: architectural register bank of the qick core.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   halt_i                : freezes all state (writes, wave load, time counter)
//   rs_A_addr_i/rs_A_dt_o : two 6-bit-address read ports, low 16 bits returned
//   rs_D_addr_i/rs_D_dt_o : two 7-bit-address read ports, 32 bits returned
//   wr_we_i/addr/dt       : write-back port from the WR stage
//   wmem_ld_i/wmem_dt_i   : whole-word wave register load
//   status_i              : core status, readable at s2
//   wreg_dt_o             : wave register state
//   jmp_addr_o            : d15, the jump address register
// Reads are combinational so forwarding logic sees contents in the same cycle.
module qcore_reg_bank
   import qick_pkg::*;
#(
   parameter int DREG_QTY = 16   // 16..32; d15 must exist as the jump register
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        halt_i,
   input  logic [5:0]  rs_A_addr_i [2],
   output logic [15:0] rs_A_dt_o   [2],
   input  logic [6:0]  rs_D_addr_i [2],
   output logic [31:0] rs_D_dt_o   [2],
   input  logic        wr_we_i,
   input  logic [6:0]  wr_addr_i,
   input  logic [31:0] wr_dt_i,
   input  logic        wmem_ld_i,
   input  WAVE_REG_T   wmem_dt_i,
   input  logic [31:0] status_i,
   output WAVE_REG_T   wreg_dt_o,
   output logic [31:0] jmp_addr_o
);

   localparam int         DAW      = $clog2(DREG_QTY);
   localparam logic [6:0] DREG_END = 7'(DREG_BASE + 7'(DREG_QTY));
   localparam logic [6:0] WREG_END = 7'(WREG_BASE + 7'(WAVE_FIELDS));
   localparam int         JMP_IDX  = int'(REG_JMP_ADDR - DREG_BASE);

   logic        wr_en;
   logic [31:0] time_q;
   logic [31:0] time_d;
   logic [31:0] sreg_q [3:15];   // s0 and s2 hold no state, s1 is time_q
   logic [31:0] dreg_q [DREG_QTY];
   WAVE_REG_T   wreg_q;

   assign wr_en = wr_we_i & ~halt_i;

   // Time register: free-running, a write-back replaces the increment.
   always_comb begin
      time_d = time_q;
      if (!halt_i) begin
         if (wr_en && (wr_addr_i == REG_TIME)) time_d = wr_dt_i;
         else                                  time_d = time_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) time_q <= '0;
      else         time_q <= time_d;
   end

   genvar gi;

   generate
      for (gi = 3; gi < 16; gi++) begin : g_sreg
         logic [31:0] sreg_d;
         always_comb begin
            sreg_d = sreg_q[gi];
            if (wr_en && (wr_addr_i == 7'(SREG_BASE + 7'(gi)))) sreg_d = wr_dt_i;
         end
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) sreg_q[gi] <= '0;
            else         sreg_q[gi] <= sreg_d;
         end
      end

      for (gi = 0; gi < DREG_QTY; gi++) begin : g_dreg
         logic [31:0] dreg_d;
         always_comb begin
            dreg_d = dreg_q[gi];
            if (wr_en && (wr_addr_i == 7'(DREG_BASE + 7'(gi)))) dreg_d = wr_dt_i;
         end
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) dreg_q[gi] <= '0;
            else         dreg_q[gi] <= dreg_d;
         end
      end
   endgenerate

   qcore_wreg u_wreg (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .halt_i    (halt_i),
      .wmem_ld_i (wmem_ld_i),
      .wmem_dt_i (wmem_dt_i),
      .wr_we_i   (wr_we_i),
      .wr_addr_i (wr_addr_i),
      .wr_dt_i   (wr_dt_i),
      .wreg_o    (wreg_q)
   );

   // Full 7-bit address decode; anything reserved or write-only-ignored
   // (s0, 0x10-0x1F, past w5, past the last dreg, 0x60-0x7F) reads 0.
   function automatic logic [31:0] rd_mux(input logic [6:0] a);
      logic [31:0] v;
      v = '0;
      case (a[6:5])
         2'b00: begin
            if (!a[4]) begin
               if (a[3:0] == REG_TIME[3:0])        v = time_q;
               else if (a[3:0] == REG_STATUS[3:0]) v = status_i;
               else if (a[3:0] != 4'd0)            v = sreg_q[a[3:0]];
            end
         end
         2'b01:   if (a < WREG_END) v = wreg_q[a[2:0]];
         2'b10:   if (a < DREG_END) v = dreg_q[a[DAW-1:0]];
         default: v = '0;
      endcase
      return v;
   endfunction

   // always_comb (not assign) so the function's reads of register state are
   // part of the sensitivity.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         always_comb begin
            rs_A_dt_o[gi] = 16'(rd_mux({1'b0, rs_A_addr_i[gi]}));
            rs_D_dt_o[gi] = rd_mux(rs_D_addr_i[gi]);
         end
      end
   endgenerate

   assign wreg_dt_o  = wreg_q;
   assign jmp_addr_o = dreg_q[JMP_IDX];

endmodule

// File: doc/qcore_reg_bank.md
# qcore_reg_bank

Architectural register bank of the qick processor core. It feeds the operand-forwarding / hazard stage through two 16-bit address read ports and two 32-bit data read ports, and takes the single write-back port from the WR stage. It also holds the wave register, which can be loaded whole from wave memory, the jump-address register, and a free-running time register. Reads are combinational, so the downstream forwarding logic sees register contents in the same cycle it compares addresses against X1/X2/WR.

## Interface
- `DREG_QTY`, default 16, number of general data registers (max 32); must be ≥16 because d15 is the jump address register.
- `clk_i` in 1, core clock.
- `rst_ni` in 1, asynchronous active-low reset.
- `halt_i` in 1, freezes all register state (writes, loads, time counter).
- `rs_A_addr_i[2]` in 6 each, address read ports; they address `{1'b0,addr}`.
- `rs_A_dt_o[2]` out 16 each, bits [15:0] of the selected register.
- `rs_D_addr_i[2]` in 7 each, data read ports.
- `rs_D_dt_o[2]` out 32 each, selected register.
- `wr_we_i` in 1, write-back enable from the WR stage.
- `wr_addr_i` in 7, write-back address.
- `wr_dt_i` in 32, write-back data.
- `wmem_ld_i` in 1, load the whole wave register.
- `wmem_dt_i` in 6x32, wave word from wave memory (field 0 in [31:0]).
- `status_i` in 32, core status word, read-only at s2.
- `wreg_dt_o` out 6x32, current wave register, registered state.
- `jmp_addr_o` out 32, current d15.

## Operation
- Address map, 7 bits:
  - `0x00` s0: reads 0; writes ignored.
  - `0x01` s1: time register; read-write.
  - `0x02` s2: reads `status_i`; writes ignored.
  - `0x03–0x0F` s3..s15: read-write.
  - `0x10–0x1F`: reserved; reads 0, writes ignored.
  - `0x20–0x25` w0..w5: wave fields; read-write.
  - `0x26–0x3F`: reserved.
  - `0x40+i` di, i < `DREG_QTY`: read-write; `0x4F` = d15 = jump address.
  - Above the last dreg: reserved.
- Read ports: purely combinational muxes, independent of each other and of `halt_i`. Reserved addresses return 0. A-ports cannot reach dregs.
- Write port: when `wr_we_i & ~halt_i`, the addressed read-write register takes `wr_dt_i` at the clock edge.
- Wave load: when `wmem_ld_i & ~halt_i`, w0..w5 take `wmem_dt_i` at the clock edge.
- Wave load and register write to a w field in the same cycle: the write-back value wins for that field; the other five fields take the load.
- Time register s1, when `~halt_i`:
  - Increments by 1 each cycle, wrapping from `0xFFFF_FFFF` to 0.
  - A write to s1 loads `wr_dt_i` instead of incrementing; increment resumes the following cycle.
- `halt_i` high: nothing changes, including s1. Pending `wr_we_i`/`wmem_ld_i` in that cycle are dropped; upstream holds them.

## Timing
- Reset: all registers 0; `rs_*_dt_o` reflect 0 (except s2 = `status_i`); `wreg_dt_o` = 0; `jmp_addr_o` = 0.
- Read latency: 0 cycles (same-cycle combinational).
- Write visibility: write at edge N is visible on read ports from cycle N+1. A same-cycle read of the register being written returns the old value; the forwarding stage covers this via its WR compare.
- `jmp_addr_o` and `wreg_dt_o` update one cycle after the write or load.
- Reset asserted mid-operation clears everything immediately, including s1.

## Structure
- Shared package `qick_pkg` (alongside `CTRL_REG`):
  - Region bases `SREG_BASE=7'h00`, `WREG_BASE=7'h20`, `DREG_BASE=7'h40`.
  - `REG_JMP_ADDR=7'h4F`, `REG_TIME=7'h01`, `REG_STATUS=7'h02`.
  - Typedef `WAVE_REG_T` (6x32).
- Sub-module `qcore_wreg`: the six wave fields with load/write merge. The time counter and sreg/dreg arrays stay in the top module.

## Test plan
- Reset, then read all 128 addresses on every port → 0 everywhere except s1 (counting from 0) and s2 = `status_i`.
- Write `0xDEADBEEF` to `0x4F` → `jmp_addr_o` and D-port read show it next cycle; A-port address `0x0F` reads s15, not d15; same-cycle read shows the old value.
- `wmem_ld_i` with fields 1..6 plus a same-cycle write `0x22`←`0xAA` → w2=`0xAA`, others 1,2,4,5,6.
- Write s1←`0xFFFF_FFFE` → reads `0xFFFF_FFFE`, `0xFFFF_FFFF`, 0 on following cycles.
- Hold `halt_i` 3 cycles with `wr_we_i` to d3 → no change in d3 or s1; release → s1 resumes from its frozen value.
- Writes to s0, s2, `0x10`, `0x30`, `0x70` → all still read 0 (s2 = `status_i`); no other register changes.
